// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped interval timer raising IRQ through a pending/in-service handshake
// Optional prescaler compiled in with macro TIMER_PRESCALER_EN (PRESCALE cycles per count step).
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Kenel,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, PENDING, IN_SERVICE} state_t;
  state_t      state_q, state_d;
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic        en_q, en_d, ie_q, ie_d, stat_q, stat_d, ovr_q, ovr_d, irq_q, irq_d;
  logic        sel_th, sel_tl, sel_tc, wr_th, wr_tl, wr_tc;
  logic        step, wrap, ovf_ie, clr_stat, clr_ovr;
`ifdef TIMER_PRESCALER_EN
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  logic [15:0] ps_q, ps_d;
  // prescale counter: idles at 0 while disabled, wraps after each count step
  always_comb begin
    step = en_q && ps_q == PS_LAST;
    ps_d = (!en_q || step) ? 16'h0 : ps_q + 16'h1;
  end
  // prescale counter register
  always_ff @(posedge clk or negedge reset)
    if (!reset) ps_q <= 16'h0;
    else ps_q <= ps_d;
`else
  assign step = en_q;
`endif
  // address decode, combinational read mux and next-state for registers and FSM
  always_comb begin
    sel_th   = Address == BASE_ADDR;
    sel_tl   = Address == BASE_ADDR + 32'd4;
    sel_tc   = Address == BASE_ADDR + 32'd8;
    wr_th    = MemWrite && sel_th;
    wr_tl    = MemWrite && sel_tl;
    wr_tc    = MemWrite && sel_tc;
    ReadData = !MemRead ? 32'h0 : sel_th ? th_q : sel_tl ? tl_q
             : sel_tc ? {28'h0, ovr_q, stat_q, ie_q, en_q} : 32'h0;
    wrap     = tl_q == 32'hFFFF_FFFF;
    ovf_ie   = step && wrap && !wr_tl && ie_q;
    clr_stat = wr_tc && !WriteData[2];
    clr_ovr  = wr_tc && !WriteData[3];
    th_d     = wr_th ? WriteData : th_q;
    tl_d     = wr_tl ? WriteData : !step ? tl_q : wrap ? th_q : tl_q + 32'd1;
    en_d     = wr_tc ? WriteData[0] : en_q;
    ie_d     = wr_tc ? WriteData[1] : ie_q;
    stat_d   = ovf_ie || (stat_q && !clr_stat);
    ovr_d    = (ovf_ie && state_q == IN_SERVICE) || (ovr_q && !clr_ovr);
    state_d  = state_q == IDLE    ? (ovf_ie ? PENDING : IDLE)
             : state_q == PENDING ? ((clr_stat && !ovf_ie) ? IDLE : Kenel ? IN_SERVICE : PENDING)
             : (clr_stat && !ovf_ie) ? IDLE : (clr_stat || !Kenel) ? PENDING : IN_SERVICE;
    irq_d    = state_q == PENDING && ie_q;
  end
  // register state; IRQ lags the FSM state by one edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      th_q    <= 32'h0;
      tl_q    <= 32'h0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      stat_q  <= 1'b0;
      ovr_q   <= 1'b0;
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      stat_q  <= stat_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  assign IRQ = irq_q;
endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source: scenario tasks with a queue of expected values for timer_irq_source
module tb_timer_irq_source;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE, A_TL = BASE + 32'd4, A_TC = BASE + 32'd8;
  logic        clk = 1'b0, reset = 1'b0, Kenel = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] Address = 32'h0, WriteData = 32'h0, ReadData;
  logic        IRQ;
  logic [31:0] sb[$];
  logic [31:0] got, exp_v;
  int          n_chk = 0, n_fail = 0;

  timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .Kenel(Kenel), .Address(Address), .MemRead(MemRead),
    .MemWrite(MemWrite), .WriteData(WriteData), .ReadData(ReadData), .IRQ(IRQ));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a;
    WriteData = d;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a;
    MemRead = 1'b1;
    #1;
    d = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sb.push_back(32'h0);
    rd(A_TH, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_th got %h want %h", got, exp_v); end
    sb.push_back(32'h0);
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_irq got %h want %h", got, exp_v); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h3);
    sb.push_back(32'hFFFF_FFFF);
    tick();
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ovf_tl_step got %h want %h", got, exp_v); end
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h7);
    sb.push_back(32'h0);
    tick();
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ovf_tl_reload got %h want %h", got, exp_v); end
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ovf_tcon got %h want %h", got, exp_v); end
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ovf_irq_latency got %h want %h", got, exp_v); end
    sb.push_back(32'h1);
    tick();
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ovf_irq got %h want %h", got, exp_v); end
    sb.push_back(32'h6);
    sb.push_back(32'h1);
    wr(A_TC, 32'h6);
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL stop_tcon got %h want %h", got, exp_v); end
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL stop_irq got %h want %h", got, exp_v); end
  endtask

  task automatic test_handshake();
    Kenel = 1'b1;
    sb.push_back(32'h0);
    tick(); tick();
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL hs_in_service_irq got %h want %h", got, exp_v); end
    Kenel = 1'b0;
    sb.push_back(32'h1);
    tick(); tick();
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL hs_reassert_irq got %h want %h", got, exp_v); end
    sb.push_back(32'h0);
    sb.push_back(32'h2);
    wr(A_TC, 32'h2);
    tick();
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL hs_clear_irq got %h want %h", got, exp_v); end
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL hs_clear_tcon got %h want %h", got, exp_v); end
  endtask

  task automatic test_nested_overflow();
    wr(A_TH, 32'hFFFF_FFFF);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    Kenel = 1'b1;
    sb.push_back(32'hF);
    sb.push_back(32'h0);
    tick(); tick(); tick();
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL nest_ovr_tcon got %h want %h", got, exp_v); end
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL nest_irq got %h want %h", got, exp_v); end
    sb.push_back(32'h0);
    tick(); tick();
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL nest_irq_hold got %h want %h", got, exp_v); end
    wr(A_TH, 32'h0);
    tick();
    sb.push_back(32'h3);
    wr(A_TC, 32'h3);
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL nest_clear_tcon got %h want %h", got, exp_v); end
    Kenel = 1'b0;
  endtask

  task automatic test_collisions();
    wr(A_TC, 32'h2);
    wr(A_TH, 32'hFFFF_FFFF);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'h3);
    tick();
    sb.push_back(32'h7);
    sb.push_back(32'h1);
    wr(A_TC, 32'h3);
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL col_stat_kept got %h want %h", got, exp_v); end
    tick();
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL col_irq got %h want %h", got, exp_v); end
    sb.push_back(32'h5);
    wr(A_TL, 32'h5);
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL col_tl_write got %h want %h", got, exp_v); end
    wr(A_TC, 32'h2);
  endtask

  task automatic test_no_ie_and_reset();
    wr(A_TC, 32'h0);
    wr(A_TH, 32'h7);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TC, 32'h1);
    sb.push_back(32'h7);
    sb.push_back(32'h1);
    tick(); tick();
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL noie_tl_reload got %h want %h", got, exp_v); end
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL noie_tcon got %h want %h", got, exp_v); end
    for (int i = 0; i < 4; i++) begin
      sb.push_back(32'h0);
      tick();
      got = {31'h0, IRQ};
      exp_v = sb.pop_front(); n_chk++;
      if (got !== exp_v) begin n_fail++; $display("FAIL noie_irq[%0d] got %h want %h", i, got, exp_v); end
    end
    sb.push_back(32'h0);
    rd(BASE + 32'd12, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL unmapped_read got %h want %h", got, exp_v); end
    sb.push_back(32'h0);
    Address = A_TH;
    #1;
    got = ReadData;
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL no_memread got %h want %h", got, exp_v); end
    reset = 1'b0;
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    rd(A_TH, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL async_rst_th got %h want %h", got, exp_v); end
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL async_rst_tl got %h want %h", got, exp_v); end
    rd(A_TC, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL async_rst_tcon got %h want %h", got, exp_v); end
    got = {31'h0, IRQ};
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL async_rst_irq got %h want %h", got, exp_v); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_prescale();
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
`ifdef TIMER_PRESCALER_EN
    sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h3);
`else
    sb.push_back(32'h3); sb.push_back(32'h4); sb.push_back(32'hC);
`endif
    repeat (3) tick();
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ps_3cyc got %h want %h", got, exp_v); end
    tick();
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ps_4cyc got %h want %h", got, exp_v); end
    repeat (8) tick();
    rd(A_TL, got);
    exp_v = sb.pop_front(); n_chk++;
    if (got !== exp_v) begin n_fail++; $display("FAIL ps_12cyc got %h want %h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_handshake();
    test_nested_overflow();
    test_collisions();
    test_no_ie_and_reset();
    test_prescale();
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_irq_source.md
Name: timer_irq_source

Overview:
Memory-mapped interval timer that originates the IRQ line consumed by the CPU's control decoder. When enabled, it counts up, reloads on overflow and raises IRQ. It tracks the request through a pending / in-service handshake using the CPU's kernel-mode bit, and holds IRQ until software clears the status. It sits on the peripheral data bus beside data memory.

Parameters:
BASE_ADDR, 32'h4000_0000, byte address of TH; TL at +4, TCON at +8.
PRESCALE, 4, clock cycles per count step; used only when the optional feature is compiled in (2..65535).

Ports:
clk  input  1  system clock, all state on posedge.
reset  input  1  asynchronous, active-low reset.
Kenel  input  1  CPU kernel-mode bit (PC[31]); 1 = interrupt handler or kernel code executing.
Address  input  32  bus byte address.
MemRead  input  1  bus read strobe.
MemWrite  input  1  bus write strobe.
WriteData  input  32  bus write data.
ReadData  output  32  bus read data.
IRQ  output  1  interrupt request to CPU.

Behaviour:
- Registers:
  - TH[31:0]: reload value, R/W.
  - TL[31:0]: counter, R/W.
  - TCON[3:0], bits [31:4] read 0:
    - TCON[0] EN, R/W.
    - TCON[1] IE, R/W.
    - TCON[2] STAT, W0C: writing 0 clears, writing 1 has no effect.
    - TCON[3] OVR, W0C.
- Reset (reset low, async): TH=0, TL=0, TCON=0, state=IDLE, IRQ=0, ReadData=0.
- Reads are combinational, zero latency: ReadData = selected register when MemRead and Address matches TH/TL/TCON, else 32'h0.
- Writes commit at posedge when MemWrite and Address matches. Other addresses are ignored.
- Count step: each cycle with EN=1, or each PRESCALE-th cycle with the feature on.
  - TL != 32'hFFFF_FFFF: TL <= TL+1.
  - TL == 32'hFFFF_FFFF: TL <= TH, and an overflow event occurs. The TL reload always happens; the event sets STAT only if IE=1.
- FSM:
  - IDLE (STAT=0): overflow with IE=1 -> PENDING, STAT<=1.
  - PENDING: IRQ = IE.
    - Software clears STAT -> IDLE.
    - Else Kenel==1 sampled -> IN_SERVICE.
  - IN_SERVICE: IRQ=0.
    - Software clears STAT -> IDLE.
    - Kenel falls to 0 with STAT still 1 (handler returned without clearing) -> PENDING, IRQ reasserts.
    - Overflow with IE=1 -> OVR<=1, stay.
- IRQ is registered: it reflects the state from the previous edge, giving 1-cycle latency from the overflow edge.
- Simultaneous events:
  - Write to TL in the same cycle as a count step: the write wins, no overflow event.
  - Write clearing STAT in the same cycle as an overflow with IE=1: overflow wins, STAT stays 1, FSM -> PENDING.
  - Write to EN=0 takes effect next cycle; the count step in the write cycle uses the old EN.
- Clearing IE while PENDING drops IRQ; STAT and the state are retained, and setting IE again reasserts IRQ.
- TH=32'hFFFF_FFFF: overflow fires every count step.
- Reset mid-operation returns everything to the reset values immediately.

Optional Feature:
- Macro TIMER_PRESCALER_EN.
- Defined: a 16-bit prescale counter, reset 0, clears on EN=0, and produces a count step when it reaches PRESCALE-1, then wraps to 0.
- Undefined: the count step is every cycle with EN=1, the prescale counter is absent and PRESCALE is ignored.

Test Plan:
1. Reset, TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3 -> TL wraps to 32'hFFFF_FFFC after 2 cycles, STAT=1, IRQ=1 one cycle later; TCON reads 32'h7.
2. From PENDING, raise Kenel -> IRQ=0 next cycle. Drop Kenel without clearing -> IRQ=1 again. Write TCON=3 -> IRQ=0, state IDLE.
3. IN_SERVICE (Kenel=1), TH=32'hFFFF_FFFF so every cycle overflows -> TCON[3]=1, IRQ stays 0. Write TCON=3 -> TCON reads 32'h3.
4. Write TCON=3 in the exact overflow cycle -> STAT remains 1, IRQ=1. Write TL=5 in a count cycle -> TL reads 5, not 6.
5. IE=0, EN=1, overflow -> TL reloads, STAT=0, IRQ never asserts. Read an unmapped address -> ReadData=0. Pull reset low mid-count -> all registers 0 asynchronously.
6. With TIMER_PRESCALER_EN and PRESCALE=4, EN=1, TL=0 -> TL=1 after 4 cycles and TL=3 after 12.
